// File: rtl/sopc_nios2_0_div_cell.sv
`default_nettype none
// ============================================================================
// Module   : sopc_nios2_0_div_cell
// Purpose  : Iterative radix-2 restoring divider, quotient and remainder,
//            start/busy/done handshake. Signed operation is built only when
//            SOPC_NIOS2_0_DIV_SIGNED_EN is defined; otherwise unsigned only.
// Revision : 1.0 - initial release
// ============================================================================
module sopc_nios2_0_div_cell #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             A_div_start,
    input  logic             A_div_signed,
    input  logic [WIDTH-1:0] A_div_src1,
    input  logic [WIDTH-1:0] A_div_src2,
    output logic             A_div_busy,
    output logic             A_div_done,
    output logic [WIDTH-1:0] A_div_quotient,
    output logic [WIDTH-1:0] A_div_remainder
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dsr;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;

    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_borrow;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;
    logic               w_div_zero;

    // Partial remainder can reach 2*divisor-1, so the shifted value needs
    // WIDTH+1 bits; the extra borrow bit of the trial decides the restore.
    assign w_shift             = {r_rem, r_dvd[WIDTH-1]};
    assign {w_borrow, w_diff}  = {1'b0, w_shift} - {2'b00, r_dsr};
    assign w_div_zero          = (A_div_src2 == '0);

`ifdef SOPC_NIOS2_0_DIV_SIGNED_EN
    logic               r_q_neg;
    logic               r_r_neg;
    logic               w_neg1;
    logic               w_neg2;

    assign w_neg1  = A_div_signed & A_div_src1[WIDTH-1];
    assign w_neg2  = A_div_signed & A_div_src2[WIDTH-1];
    assign w_mag1  = w_neg1 ? (WIDTH'(0) - A_div_src1) : A_div_src1;
    assign w_mag2  = w_neg2 ? (WIDTH'(0) - A_div_src2) : A_div_src2;
    assign w_q_fix = r_q_neg ? (WIDTH'(0) - r_dvd) : r_dvd;
    assign w_r_fix = r_r_neg ? (WIDTH'(0) - r_rem) : r_rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
        end else if (r_state == S_IDLE && A_div_start) begin
            // Divide-by-zero returns raw operands, so no sign fix is applied.
            r_q_neg <= ~w_div_zero & (w_neg1 ^ w_neg2);
            r_r_neg <= ~w_div_zero & w_neg1;
        end
    end
`else
    logic               w_unused_signed;

    assign w_unused_signed = A_div_signed;
    assign w_mag1          = A_div_src1;
    assign w_mag2          = A_div_src2;
    assign w_q_fix         = r_dvd;
    assign w_r_fix         = r_rem;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dsr       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (A_div_start) begin
                        r_busy <= 1'b1;
                        r_cnt  <= '0;
                        r_dsr  <= w_mag2;
                        if (w_div_zero) begin
                            // Preload the final answer so FIX passes it through.
                            r_dvd   <= '1;
                            r_rem   <= A_div_src1;
                            r_state <= S_FIX;
                        end else begin
                            r_dvd   <= w_mag1;
                            r_rem   <= '0;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_dvd <= {r_dvd[WIDTH-2:0], ~w_borrow};
                    r_rem <= w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last_iter) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_quotient  <= w_q_fix;
                    r_remainder <= w_r_fix;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign A_div_busy      = r_busy;
    assign A_div_done      = r_done;
    assign A_div_quotient  = r_quotient;
    assign A_div_remainder = r_remainder;

endmodule
`default_nettype wire

// File: tb/tb_sopc_nios2_0_div_cell.sv
`default_nettype none
// ============================================================================
// Module   : tb_sopc_nios2_0_div_cell
// Purpose  : Scoreboard bench for the divider cell; expectations follow the
//            build (SOPC_NIOS2_0_DIV_SIGNED_EN selects signed results).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sopc_nios2_0_div_cell;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             A_div_start = 1'b0;
    logic             A_div_signed = 1'b0;
    logic [WIDTH-1:0] A_div_src1 = '0;
    logic [WIDTH-1:0] A_div_src2 = '0;
    logic             A_div_busy;
    logic             A_div_done;
    logic [WIDTH-1:0] A_div_quotient;
    logic [WIDTH-1:0] A_div_remainder;

    sopc_nios2_0_div_cell #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk             (clk),
        .reset           (reset),
        .A_div_start     (A_div_start),
        .A_div_signed    (A_div_signed),
        .A_div_src1      (A_div_src1),
        .A_div_src2      (A_div_src2),
        .A_div_busy      (A_div_busy),
        .A_div_done      (A_div_done),
        .A_div_quotient  (A_div_quotient),
        .A_div_remainder (A_div_remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        int               due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (A_div_done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_done: q=%h r=%h with nothing outstanding (cycle %0d)",
                         A_div_quotient, A_div_remainder, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", A_div_quotient, e.q);
                check("remainder", A_div_remainder, e.r);
                check("done_cycle", WIDTH'(cyc), WIDTH'(e.due));
                check("busy_at_done", {31'd0, A_div_busy}, 32'd0);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                         input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er);
        exp_t e;
        e.q   = eq;
        e.r   = er;
        e.due = cyc + 1 + ((b == '0) ? 1 : WIDTH + 1);
        sb.push_back(e);
        A_div_src1   = a;
        A_div_src2   = b;
        A_div_signed = s;
        A_div_start  = 1'b1;
        @(negedge clk);
        A_div_start  = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && A_div_busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, A_div_busy}, 32'd0);
        check("reset_done", {31'd0, A_div_done}, 32'd0);
        check("reset_quotient", A_div_quotient, 32'd0);
        check("reset_remainder", A_div_remainder, 32'd0);

        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        check("busy_after_start", {31'd0, A_div_busy}, 32'd1);
        drain();

`ifdef SOPC_NIOS2_0_DIV_SIGNED_EN
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        drain();
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
        drain();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
        drain();
`else
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1);
        drain();
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd7);
        drain();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000);
        drain();
`endif
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);
        drain();

        issue(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5);
        drain();
        issue(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        drain();

        // Start while busy must be ignored.
        issue(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0);
        repeat (8) @(negedge clk);
        check("busy_mid_op", {31'd0, A_div_busy}, 32'd1);
        A_div_src1  = 32'd77;
        A_div_src2  = 32'd3;
        A_div_start = 1'b1;
        @(negedge clk);
        A_div_start = 1'b0;
        drain();

        // Start in the done cycle is accepted; outputs hold old result meanwhile.
        issue(32'd1000, 32'd7, 1'b0, 32'd142, 32'd6);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (A_div_done === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("first_done_seen", {31'd0, seen}, 32'd1);
        issue(32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF);
        repeat (5) @(negedge clk);
        check("hold_quotient", A_div_quotient, 32'd142);
        check("hold_remainder", A_div_remainder, 32'd6);
        check("busy_second", {31'd0, A_div_busy}, 32'd1);
        drain();

        // Reset mid-operation discards the operation.
        issue(32'd12345, 32'd11, 1'b0, 32'd1122, 32'd3);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        check("midreset_busy", {31'd0, A_div_busy}, 32'd0);
        check("midreset_done", {31'd0, A_div_done}, 32'd0);
        check("midreset_quotient", A_div_quotient, 32'd0);
        check("midreset_remainder", A_div_remainder, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (A_div_done === 1'b1) seen = 1;
        end
        check("no_done_after_reset", {31'd0, seen}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
